// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access size codes, FSM states and byte-lane masks.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [3:0] LANE_BYTE = 4'b0001;
  localparam logic [3:0] LANE_HALF = 4'b0011;
  localparam logic [3:0] LANE_WORD = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_RESP} state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return LANE_BYTE;
      SZ_HALF: return LANE_HALF;
      default: return LANE_WORD;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store data shift, load merge and sign/zero extension.
// LSU_MISALIGN_SPLIT_EN enables reporting of accesses that spill into the next word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4
) (
  input  logic [1:0]                size,
  input  logic [1:0]                off,
  input  logic                      second,
  input  logic                      is_unsigned,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH-1:0]     rdata,
  input  logic [DATA_WIDTH-1:0]     res,
  output logic [TRANSFER_WIDTH-1:0] lanes,
  output logic [DATA_WIDTH-1:0]     lane_wdata,
  output logic [DATA_WIDTH-1:0]     res_next,
  output logic [DATA_WIDTH-1:0]     res_ext,
  output logic                      split
);
  localparam int TW = TRANSFER_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [2*TW-1:0] mask2;
  logic [2*DW-1:0] wdata2;

  // Work in a two-word window: the upper half is what spills into the next word.
  always_comb begin
    mask2  = (2*TW)'(size_mask(size)) << off;
    wdata2 = (2*DW)'(wdata) << (8*off);
`ifdef LSU_MISALIGN_SPLIT_EN
    split  = |mask2[2*TW-1:TW];
`else
    split  = 1'b0;
`endif
    lanes      = second ? mask2[2*TW-1:TW] : mask2[TW-1:0];
    lane_wdata = second ? wdata2[2*DW-1:DW] : wdata2[DW-1:0];
    // Second word supplies the bytes above the 4-off bytes taken from the first.
    res_next   = second ? (res | (rdata << (DW - 8*off))) : (rdata >> (8*off));
  end

  always_comb begin
    case (size)
      SZ_BYTE: res_ext = {{(DW-8){res[7] & ~is_unsigned}}, res[7:0]};
      SZ_HALF: res_ext = {{(DW-16){res[15] & ~is_unsigned}}, res[15:0]};
      default: res_ext = res;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single-request FSM driving a byte-lane data memory.
// LSU_MISALIGN_SPLIT_EN: misaligned accesses split over two words instead of being rejected.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int MEM_DEPTH      = 1 << (ADDR_WIDTH-2)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [TRANSFER_WIDTH-1:0] mem_transfer,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);
  state_e state, state_nxt;
  logic alive, hs, bad;
  logic we_q, uns_q, err_q;
  logic [1:0] size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, res_q;
  logic [ADDR_WIDTH-3:0] idx0;
  logic [TRANSFER_WIDTH-1:0] lanes;
  logic [DATA_WIDTH-1:0] lane_wdata, res_next, res_ext;
  logic split;

  // alive keeps ready low until the first clock after reset release.
  assign req_ready = alive && (state == S_IDLE);
  assign hs        = req_valid && req_ready;
  assign idx0      = req_addr[ADDR_WIDTH-1:2];

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [ADDR_WIDTH-3:0] idx1;
  assign idx1 = idx0 + (ADDR_WIDTH-2)'(1);
`endif

  always_comb begin
    bad = (req_size == SZ_BAD) || (32'(idx0) >= MEM_DEPTH);
`ifdef LSU_MISALIGN_SPLIT_EN
    if (({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4)
      bad = bad || (32'(idx1) >= MEM_DEPTH);
`else
    if ((req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00))
      bad = 1'b1;
`endif
  end

  lsu_align #(.DATA_WIDTH(DATA_WIDTH), .TRANSFER_WIDTH(TRANSFER_WIDTH)) u_align (
    .size(size_q), .off(addr_q[1:0]), .second(state == S_ACC2), .is_unsigned(uns_q),
    .wdata(wdata_q), .rdata(mem_rdata), .res(res_q),
    .lanes(lanes), .lane_wdata(lane_wdata), .res_next(res_next), .res_ext(res_ext), .split(split)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      alive   <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
      if (hs) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= bad;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        res_q   <= '0;
      end else if ((state == S_ACC1 || state == S_ACC2) && !we_q) begin
        res_q <= res_next;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_transfer = '0;
    case (state)
      S_IDLE: if (hs) state_nxt = bad ? S_RESP : S_ACC1;
      S_ACC1: begin
        mem_addr     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        mem_we       = we_q && (|lanes);
        mem_transfer = we_q ? lanes : '0;
        mem_wdata    = we_q ? lane_wdata : '0;
        state_nxt    = split ? S_ACC2 : S_RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACC2: begin
        mem_addr     = {addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1), 2'b00};
        mem_we       = we_q && (|lanes);
        mem_transfer = we_q ? lanes : '0;
        mem_wdata    = we_q ? lane_wdata : '0;
        state_nxt    = S_RESP;
      end
`endif
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? res_ext : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl with a byte-lane memory model; expectations follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_ctrl;
  import lsu_pkg::*;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [1:0] req_size = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_we;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [TW-1:0] mem_transfer;
  logic s_req_ready, s_rsp_valid, s_rsp_err, s_mem_we;
  logic [DW-1:0] s_rsp_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [TW-1:0] s_mem_transfer;

  int n_chk = 0;
  int n_fail = 0;

  lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(TW), .MEM_DEPTH(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_transfer(mem_transfer), .mem_rdata(mem_rdata));

  // Shallow instance sees the same requests; only its error responses are checked.
  lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(TW), .MEM_DEPTH(128)) u_small (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .mem_we(s_mem_we),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_transfer(s_mem_transfer), .mem_rdata('0));

  logic [DW-1:0] mem [256] = '{default: '0};
  assign mem_rdata = mem_we ? '0 : mem[mem_addr[AW-1:2]];
  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < TW; b++)
        if (mem_transfer[b]) mem[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  typedef struct {
    string nm; logic we; logic [AW-1:0] addr; logic [1:0] size; logic uns; logic [31:0] wdata;
    logic err; int lat; logic [31:0] rdata;
    logic [AW-1:0] a1; logic [3:0] t1; logic [31:0] w1;
    logic [AW-1:0] a2; logic [3:0] t2; logic [31:0] w2;
    logic s_err;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    int lat = 0;
    logic [AW-1:0] a1 = '0, a2 = '0;
    logic [3:0] t1 = '0, t2 = '0;
    logic [31:0] w1 = '0, w2 = '0, rd = '0;
    logic anywe = 1'b0, s_err = 1'b0, got_err = 1'b0;
    @(negedge clk);
    chk({v.nm, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_we) anywe = 1'b1;
      if (s_rsp_valid && s_rsp_err) s_err = 1'b1;
      if (c == 1) begin a1 = mem_addr; t1 = mem_transfer; w1 = mem_wdata; end
      if (c == 2) begin a2 = mem_addr; t2 = mem_transfer; w2 = mem_wdata; end
      if (rsp_valid) begin lat = c; got_err = rsp_err; rd = rsp_rdata; break; end
    end
    chk({v.nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.nm, " rsp_err"}, 32'(got_err), 32'(v.err));
    chk({v.nm, " rsp_rdata"}, rd, v.rdata);
    chk({v.nm, " addr1"}, 32'(a1), 32'(v.a1));
    chk({v.nm, " lanes1"}, 32'(t1), 32'(v.t1));
    chk({v.nm, " wdata1"}, w1, v.w1);
    chk({v.nm, " addr2"}, 32'(a2), 32'(v.a2));
    chk({v.nm, " lanes2"}, 32'(t2), 32'(v.t2));
    chk({v.nm, " wdata2"}, w2, v.w2);
    chk({v.nm, " any_we"}, 32'(anywe), 32'(v.we && !v.err));
    chk({v.nm, " small_err"}, 32'(s_err), 32'(v.s_err));
    @(negedge clk);
    chk({v.nm, " pulse_end"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    // name we addr size uns wdata | err lat rdata | a1 t1 w1 | a2 t2 w2 | small_err
    vq.push_back('{"st_w",   1'b1, 10'h010, SZ_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 2, 32'h0, 10'h010, 4'hF, 32'hDEADBEEF, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_w",   1'b0, 10'h010, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 32'hDEADBEEF, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"st_b5a", 1'b1, 10'h013, SZ_BYTE, 1'b0, 32'h5A, 1'b0, 2, 32'h0, 10'h010, 4'h8, 32'h5A000000, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_b5a", 1'b0, 10'h013, SZ_BYTE, 1'b0, 32'h0, 1'b0, 2, 32'h5A, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"st_b80", 1'b1, 10'h013, SZ_BYTE, 1'b0, 32'h80, 1'b0, 2, 32'h0, 10'h010, 4'h8, 32'h80000000, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_bs",  1'b0, 10'h013, SZ_BYTE, 1'b0, 32'h0, 1'b0, 2, 32'hFFFFFF80, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_bu",  1'b0, 10'h013, SZ_BYTE, 1'b1, 32'h0, 1'b0, 2, 32'h80, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_hs2", 1'b0, 10'h012, SZ_HALF, 1'b0, 32'h0, 1'b0, 2, 32'hFFFF80AD, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_hu0", 1'b0, 10'h010, SZ_HALF, 1'b1, 32'h0, 1'b0, 2, 32'h0000BEEF, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_hs0", 1'b0, 10'h010, SZ_HALF, 1'b0, 32'h0, 1'b0, 2, 32'hFFFFBEEF, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"st_h",   1'b1, 10'h020, SZ_HALF, 1'b0, 32'h1234, 1'b0, 2, 32'h0, 10'h020, 4'h3, 32'h00001234, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_w20", 1'b0, 10'h020, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 32'h00001234, 10'h020, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"bad_ld", 1'b0, 10'h030, SZ_BAD,  1'b0, 32'h0, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"bad_st", 1'b1, 10'h030, SZ_BAD,  1'b0, 32'hFFFFFFFF, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"st_bu",  1'b1, 10'h011, SZ_BYTE, 1'b1, 32'hC3, 1'b0, 2, 32'h0, 10'h010, 4'h2, 32'h0000C300, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_bc3", 1'b0, 10'h011, SZ_BYTE, 1'b0, 32'h0, 1'b0, 2, 32'hFFFFFFC3, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
`ifdef LSU_MISALIGN_SPLIT_EN
    vq.push_back('{"st_w6",  1'b1, 10'h006, SZ_WORD, 1'b0, 32'h11223344, 1'b0, 3, 32'h0, 10'h004, 4'hC, 32'h33440000, 10'h008, 4'h3, 32'h00001122, 1'b0});
    vq.push_back('{"ld_w6",  1'b0, 10'h006, SZ_WORD, 1'b0, 32'h0, 1'b0, 3, 32'h11223344, 10'h004, 4'h0, 32'h0, 10'h008, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"st_hw",  1'b1, 10'h3FF, SZ_HALF, 1'b0, 32'hABCD, 1'b0, 3, 32'h0, 10'h3FC, 4'h8, 32'hCD000000, 10'h000, 4'h1, 32'h000000AB, 1'b1});
    vq.push_back('{"ld_hw",  1'b0, 10'h3FF, SZ_HALF, 1'b0, 32'h0, 1'b0, 3, 32'hFFFFABCD, 10'h3FC, 4'h0, 32'h0, 10'h000, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"st_h5",  1'b1, 10'h005, SZ_HALF, 1'b0, 32'h5566, 1'b0, 2, 32'h0, 10'h004, 4'h6, 32'h00556600, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_w4",  1'b0, 10'h004, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 32'h33556600, 10'h004, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_b7",  1'b0, 10'h007, SZ_BYTE, 1'b1, 32'h0, 1'b0, 2, 32'h00000033, 10'h004, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
`else
    vq.push_back('{"st_w6",  1'b1, 10'h006, SZ_WORD, 1'b0, 32'h11223344, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"ld_w6",  1'b0, 10'h006, SZ_WORD, 1'b0, 32'h0, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"st_hw",  1'b1, 10'h3FF, SZ_HALF, 1'b0, 32'hABCD, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"ld_hw",  1'b0, 10'h3FF, SZ_HALF, 1'b0, 32'h0, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"st_h5",  1'b1, 10'h005, SZ_HALF, 1'b0, 32'h5566, 1'b1, 1, 32'h0, 10'h0, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b1});
    vq.push_back('{"ld_w4",  1'b0, 10'h004, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 32'h0, 10'h004, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
    vq.push_back('{"ld_b7",  1'b0, 10'h007, SZ_BYTE, 1'b1, 32'h0, 1'b0, 2, 32'h0, 10'h004, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
`endif

    // Reset state
    #12;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rsp", 32'({rsp_valid, rsp_err, |rsp_rdata}), 32'd0);
    chk("rst mem", 32'({mem_we, |mem_addr, |mem_wdata, |mem_transfer}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready before clock", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready after clock", 32'(req_ready), 32'd1);

    for (int i = 0; i < vq.size(); i++) run(vq[i]);

    // Reset in the middle of an access: outputs drop at once, no response follows
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_SPLIT_EN
    req_addr = 10'h006;
`else
    req_addr = 10'h010;
`endif
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge clk);
`endif
    chk("mid access we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst mem", 32'({mem_we, |mem_addr, |mem_wdata, |mem_transfer}), 32'd0);
    chk("mid rst rsp", 32'({rsp_valid, rsp_err, |rsp_rdata, req_ready}), 32'd0);
    chk("mid rst small", 32'({s_mem_we, |s_mem_addr, |s_mem_wdata, |s_mem_transfer, |s_rsp_rdata, s_req_ready}), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    chk("no rsp after rst", 32'(seen), 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // First word of the abandoned split store stays written
    run('{"ld_after", 1'b0, 10'h004, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 32'hF00D6600, 10'h004, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
`else
    run('{"ld_after", 1'b0, 10'h010, SZ_WORD, 1'b0, 32'h0, 1'b0, 2, 32'h80ADC3EF, 10'h010, 4'h0, 32'h0, 10'h0, 4'h0, 32'h0, 1'b0});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
